inst_fetch_unit: RTL and testbench

//  Initiator side of the instruction ROM. Owns the PC and IR for the multi-cycle MIPS core.
//  On request from the control FSM it drives the ROM word address, waits out the 1-cycle

---
 rtl/fetch_pkg.sv | 15 +
 rtl/inst_fetch_unit_if.sv | 29 ++
 rtl/inst_fetch_unit_npc_calc.sv | 29 ++
 rtl/inst_fetch_unit.sv | 69 ++++++
 tb/tb_inst_fetch_unit.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: next-PC source codes and FSM states.
package fetch_pkg;

    localparam logic [1:0] PC_SRC_SEQ = 2'b00;
    localparam logic [1:0] PC_SRC_BR  = 2'b01;
    localparam logic [1:0] PC_SRC_J   = 2'b10;
    localparam logic [1:0] PC_SRC_JR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch handshake, PC/IR visibility and instruction ROM bus of the fetch unit.
interface inst_fetch_unit_if #(
    parameter int ADDR_W = 8
) ();

    logic              fetch_req;
    logic              fetch_ready;
    logic              fetch_done;
    logic              pc_update;
    logic [1:0]        pc_src;
    logic [31:0]       jr_target;
    logic [31:0]       pc_out;
    logic [31:0]       pc_plus4;
    logic [31:0]       ir_out;
    logic              addr_err;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_inst;

    modport slave (
        input  fetch_req, pc_update, pc_src, jr_target, rom_inst,
        output fetch_ready, fetch_done, pc_out, pc_plus4, ir_out, addr_err, rom_addr
    );

    modport master (
        output fetch_req, pc_update, pc_src, jr_target, rom_inst,
        input  fetch_ready, fetch_done, pc_out, pc_plus4, ir_out, addr_err, rom_addr
    );

endinterface

// File: rtl/inst_fetch_unit_npc_calc.sv
// Combinational next-PC selection for sequential, branch, jump and jump-register flow.
module npc_calc
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [25:0] ir,        // only the jump/branch immediate fields of IR matter here
    input  logic [1:0]  pc_src,
    input  logic [31:0] jr_target,
    output logic [31:0] npc,
    output logic [31:0] pc_plus4
);

    logic signed [31:0] br_off;

    assign pc_plus4 = pc + 32'd4;
    assign br_off   = {{14{ir[15]}}, ir[15:0], 2'b00};

    always_comb begin
        npc = pc_plus4;
        unique case (pc_src)
            PC_SRC_SEQ: npc = pc_plus4;
            PC_SRC_BR:  npc = pc_plus4 + $unsigned(br_off);
            PC_SRC_J:   npc = {pc_plus4[31:28], ir[25:0], 2'b00};
            PC_SRC_JR:  npc = jr_target;
            default:    npc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns PC and IR, drives the synchronous instruction ROM
// and retires one fetch every two cycles at most.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter int          ROM_DEPTH = 50,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    inst_fetch_unit_if.slave fbus
);

    fetch_state_e state, next_state;
    logic [31:0]  pc;
    logic [31:0]  ir;
    logic [31:0]  npc;
    logic [31:0]  pc_plus4;
    logic         accept;

    npc_calc u_npc_calc (
        .pc        (pc),
        .ir        (ir[25:0]),
        .pc_src    (fbus.pc_src),
        .jr_target (fbus.jr_target),
        .npc       (npc),
        .pc_plus4  (pc_plus4)
    );

    assign fbus.fetch_ready = (state != READ);
    assign fbus.fetch_done  = (state == DONE);
    // A same-cycle PC update wins; the request is taken on the new PC next cycle.
    assign accept = fbus.fetch_req & fbus.fetch_ready & ~fbus.pc_update;

    assign fbus.pc_out   = pc;
    assign fbus.pc_plus4 = pc_plus4;
    assign fbus.ir_out   = ir;
    assign fbus.rom_addr = pc[ADDR_W+1:2];
    assign fbus.addr_err = (pc[1:0] != 2'b00) || ({2'b00, pc[31:2]} >= 32'(ROM_DEPTH));

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (accept) next_state = READ;
            READ:    next_state = DONE;
            DONE:    next_state = accept ? READ : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // READ lasts exactly one cycle, so an update arriving in READ is deferred only
    // to the READ->DONE edge, i.e. the next edge; the ROM already holds the old address.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
            ir <= '0;
        end else begin
            if (fbus.pc_update) pc <= npc;
            if (state == READ)  ir <= fbus.rom_inst;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed program-image scenarios then randomized traffic
// against a cycle-level behavioural model with a synchronous ROM.
module tb_inst_fetch_unit;

    localparam int ADDR_W    = 8;
    localparam int ROM_DEPTH = 50;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    inst_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

    inst_fetch_unit #(
        .ADDR_W    (ADDR_W),
        .ROM_DEPTH (ROM_DEPTH),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .fbus  (bus)
    );

    logic [31:0] rom [256];
    always @(posedge clk) bus.rom_inst <= rom[bus.rom_addr];

    int n_assert = 0;
    int n_fail   = 0;

    // Model: stage 0 = nothing in flight, 1 = ROM read under way, 2 = word just delivered
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    int          m_stage;
    int          m_faddr;

    function automatic logic [31:0] ref_npc(logic [31:0] pc, logic [31:0] ir,
                                            logic [1:0] src, logic [31:0] jr);
        logic [31:0] seq;
        int          off;
        seq = pc + 32'd4;
        case (src)
            2'd0:    return seq;
            2'd1: begin
                off = int'($signed(ir[15:0])) * 4;
                return seq + 32'(off);
            end
            2'd2:    return (seq & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) << 2);
            default: return jr;
        endcase
    endfunction

    function automatic logic ref_err(logic [31:0] pc);
        return ((pc % 4) != 0) || ((pc / 4) >= 32'(ROM_DEPTH));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".ready"},    32'(bus.fetch_ready), 32'(m_stage != 1));
        chk({ctx, ".done"},     32'(bus.fetch_done),  32'(m_stage == 2));
        chk({ctx, ".pc"},       bus.pc_out,           m_pc);
        chk({ctx, ".pc_plus4"}, bus.pc_plus4,         m_pc + 32'd4);
        chk({ctx, ".ir"},       bus.ir_out,           m_ir);
        chk({ctx, ".addr_err"}, 32'(bus.addr_err),    32'(ref_err(m_pc)));
        chk({ctx, ".rom_addr"}, 32'(bus.rom_addr),    (m_pc >> 2) % 256);
    endtask

    task automatic do_cycle(input string ctx, input logic r, input logic q, input logic u,
                            input logic [1:0] s, input logic [31:0] j);
        logic [31:0] new_pc;
        logic        acc;
        int          nstage;
        reset             = r;
        bus.fetch_req     = q;
        bus.pc_update     = u;
        bus.pc_src        = s;
        bus.jr_target     = j;
        @(posedge clk);
        if (r) begin
            m_pc    = 32'h0;
            m_ir    = 32'h0;
            m_stage = 0;
        end else begin
            acc    = q && (m_stage != 1) && !u;
            new_pc = u ? ref_npc(m_pc, m_ir, s, j) : m_pc;
            nstage = 0;
            if (m_stage == 1) begin
                m_ir   = rom[m_faddr];
                nstage = 2;
            end
            if (acc) begin
                m_faddr = int'((m_pc >> 2) % 256);
                nstage  = 1;
            end
            m_pc    = new_pc;
            m_stage = nstage;
        end
        @(negedge clk);
        check_all(ctx);
    endtask

    task automatic fetch_once(input string ctx);
        do_cycle({ctx, ".acc"}, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0);
        do_cycle({ctx, ".ret"}, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
    endtask

    task automatic set_pc(input string ctx, input logic [31:0] a);
        do_cycle(ctx, 1'b0, 1'b0, 1'b1, 2'b11, a);
    endtask

    initial begin
        logic [31:0] jr;
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        rom[0]  = 32'h3c010000;
        rom[1]  = 32'h34240000;
        rom[3]  = 32'h0c000018;
        rom[4]  = 32'hac820000;
        rom[8]  = 32'h24a5ffff;
        rom[24] = 32'h00004021;
        rom[29] = 32'h14a0fffc;
        m_pc = 32'h0; m_ir = 32'h0; m_stage = 0; m_faddr = 0;

        do_cycle("rst0", 1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
        do_cycle("rst1", 1'b1, 1'b1, 1'b0, 2'b00, 32'h0);
        chk("rst.pc", bus.pc_out, 32'h0);
        chk("rst.ir", bus.ir_out, 32'h0);
        chk("rst.done", 32'(bus.fetch_done), 32'h0);

        // Scenario 1: request held from reset, done after two edges
        do_cycle("t1.c1", 1'b0, 1'b1, 1'b0, 2'b00, 32'h0);
        do_cycle("t1.c2", 1'b0, 1'b1, 1'b0, 2'b00, 32'h0);
        chk("t1.done", 32'(bus.fetch_done), 32'h1);
        chk("t1.ir", bus.ir_out, 32'h3c010000);
        do_cycle("t1.seq", 1'b0, 1'b0, 1'b1, 2'b00, 32'h0);
        chk("t1.pc", bus.pc_out, 32'h4);

        // Scenario 2: jal at 0x0C
        set_pc("t2.set", 32'h0C);
        fetch_once("t2.f");
        chk("t2.ir", bus.ir_out, 32'h0c000018);
        chk("t2.link", bus.pc_plus4, 32'h10);
        do_cycle("t2.j", 1'b0, 1'b0, 1'b1, 2'b10, 32'h0);
        chk("t2.pc", bus.pc_out, 32'h60);
        fetch_once("t2.f2");
        chk("t2.ir2", bus.ir_out, 32'h00004021);

        // Scenario 3: backward bne, then jr
        set_pc("t3.set", 32'h74);
        fetch_once("t3.f");
        chk("t3.ir", bus.ir_out, 32'h14a0fffc);
        do_cycle("t3.br", 1'b0, 1'b0, 1'b1, 2'b01, 32'h0);
        chk("t3.pc_br", bus.pc_out, 32'h68);
        do_cycle("t3.jr", 1'b0, 1'b0, 1'b1, 2'b11, 32'h10);
        chk("t3.pc_jr", bus.pc_out, 32'h10);
        fetch_once("t3.f2");
        chk("t3.ir2", bus.ir_out, 32'hac820000);

        // Scenario 4: PC update during READ
        set_pc("t4.set", 32'h20);
        do_cycle("t4.acc", 1'b0, 1'b1, 1'b0, 2'b00, 32'h0);
        do_cycle("t4.upd", 1'b0, 1'b0, 1'b1, 2'b00, 32'h0);
        chk("t4.done", 32'(bus.fetch_done), 32'h1);
        chk("t4.ir", bus.ir_out, 32'h24a5ffff);
        chk("t4.pc", bus.pc_out, 32'h24);

        // Scenario 5: request and update in the same cycle
        set_pc("t5.set", 32'h0);
        do_cycle("t5.both", 1'b0, 1'b1, 1'b1, 2'b00, 32'h0);
        chk("t5.pc", bus.pc_out, 32'h4);
        chk("t5.ready", 32'(bus.fetch_ready), 32'h1);
        fetch_once("t5.f");
        chk("t5.ir", bus.ir_out, 32'h34240000);

        // Scenario 6: address errors, wraparound, reset during READ
        set_pc("t6.mis", 32'h102);
        chk("t6.err_mis", 32'(bus.addr_err), 32'h1);
        set_pc("t6.oor", 32'hC8);
        chk("t6.err_oor", 32'(bus.addr_err), 32'h1);
        set_pc("t6.ok", 32'hC4);
        chk("t6.err_ok", 32'(bus.addr_err), 32'h0);
        set_pc("t6.top", 32'hFFFF_FFFC);
        do_cycle("t6.wrap", 1'b0, 1'b0, 1'b1, 2'b00, 32'h0);
        chk("t6.wrap_pc", bus.pc_out, 32'h0);
        set_pc("t6.set", 32'h10);
        do_cycle("t6.acc", 1'b0, 1'b1, 1'b0, 2'b00, 32'h0);
        do_cycle("t6.rst", 1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
        chk("t6.rst_done", 32'(bus.fetch_done), 32'h0);
        chk("t6.rst_pc", bus.pc_out, 32'h0);
        do_cycle("t6.post", 1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
        chk("t6.post_done", 32'(bus.fetch_done), 32'h0);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            jr = ($urandom_range(0, 3) != 0) ? {24'h0, 2'b00, 6'($urandom_range(0, 63))} << 0
                                              : 32'($urandom);
            if ($urandom_range(0, 3) != 0) jr = {22'h0, 8'($urandom_range(0, 63)), 2'b00};
            do_cycle("rnd",
                     ($urandom_range(0, 99) == 0),
                     ($urandom_range(0, 9) < 7),
                     ($urandom_range(0, 4) == 0),
                     2'($urandom_range(0, 3)),
                     jr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
